// File: rtl/histo_packetizer.sv
// histo_packetizer
// After a start pulse, reads every histogram bin in address order and streams
// one framed packet over a valid/ready byte interface:
//   SYNC0, SYNC1, frame_id, bin counts (MSB first), 8-bit checksum.
// The checksum is the mod-256 sum of frame_id and every count byte.
module histo_packetizer #(
  parameter int         BINS    = 1024,
  parameter int         BIN_W   = 10,
  parameter int         COUNT_W = 24,
  parameter logic [7:0] SYNC0   = 8'hAA,
  parameter logic [7:0] SYNC1   = 8'h55
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [7:0]         frame_id,
  output logic               rd_en,
  output logic [BIN_W-1:0]   rd_addr,
  input  logic [COUNT_W-1:0] rd_data,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic               busy,
  output logic               done
);

  localparam int NB    = COUNT_W / 8;
  localparam int CNT_W = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NB - 1);
  localparam logic [BIN_W-1:0] LAST_BIN  = BIN_W'(BINS - 1);

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_SYNC0 = 4'd1,
    ST_SYNC1 = 4'd2,
    ST_FID   = 4'd3,
    ST_FETCH = 4'd4,
    ST_LATCH = 4'd5,
    ST_SEND  = 4'd6,
    ST_CSUM  = 4'd7,
    ST_DONE  = 4'd8
  } state_t;

  // Running checksum update: plain 8-bit wrap-around add.
  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    csum_add = acc + b;
  endfunction

  // Most significant byte of a count word, i.e. the next byte to transmit.
  function automatic logic [7:0] top_byte(input logic [COUNT_W-1:0] w);
    top_byte = w[COUNT_W-1 -: 8];
  endfunction

  state_t             state_r,    state_s;
  logic [7:0]         tx_data_r,  tx_data_s;
  logic               tx_valid_r, tx_valid_s;
  logic               rd_en_r,    rd_en_s;
  logic [BIN_W-1:0]   rd_addr_r,  rd_addr_s;
  logic               busy_r,     busy_s;
  logic               done_r,     done_s;
  logic [COUNT_W-1:0] shift_r,    shift_s;
  logic [7:0]         csum_r,     csum_s;
  logic [CNT_W-1:0]   byte_cnt_r, byte_cnt_s;
  logic [7:0]         fid_r,      fid_s;
  logic               xfer_s;

  assign xfer_s = tx_valid_r & tx_ready;

  // Next-state and next-output computation; every register holds by default.
  always_comb begin
    state_s    = state_r;
    tx_data_s  = tx_data_r;
    tx_valid_s = tx_valid_r;
    rd_en_s    = rd_en_r;
    rd_addr_s  = rd_addr_r;
    busy_s     = busy_r;
    done_s     = done_r;
    shift_s    = shift_r;
    csum_s     = csum_r;
    byte_cnt_s = byte_cnt_r;
    fid_s      = fid_r;

    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s    = ST_SYNC0;
          fid_s      = frame_id;
          busy_s     = 1'b1;
          csum_s     = 8'h00;
          rd_addr_s  = {BIN_W{1'b0}};
          tx_data_s  = SYNC0;
          tx_valid_s = 1'b1;
        end else begin
          state_s    = ST_IDLE;
        end
      end

      ST_SYNC0: begin
        if (xfer_s) begin
          state_s   = ST_SYNC1;
          tx_data_s = SYNC1;
        end else begin
          state_s   = ST_SYNC0;
        end
      end

      ST_SYNC1: begin
        if (xfer_s) begin
          state_s   = ST_FID;
          tx_data_s = fid_r;
        end else begin
          state_s   = ST_SYNC1;
        end
      end

      ST_FID: begin
        // frame_id is part of the checksum; the first bin read follows it.
        if (xfer_s) begin
          state_s    = ST_FETCH;
          csum_s     = csum_add(csum_r, tx_data_r);
          tx_valid_s = 1'b0;
          rd_addr_s  = {BIN_W{1'b0}};
          rd_en_s    = 1'b1;
        end else begin
          state_s    = ST_FID;
        end
      end

      ST_FETCH: begin
        // rd_en is high during this cycle only; data returns next cycle.
        state_s = ST_LATCH;
        rd_en_s = 1'b0;
      end

      ST_LATCH: begin
        // Top byte goes straight to the output; the rest waits in shift_r.
        state_s    = ST_SEND;
        tx_data_s  = top_byte(rd_data);
        shift_s    = rd_data << 4'd8;
        tx_valid_s = 1'b1;
        byte_cnt_s = {CNT_W{1'b0}};
      end

      ST_SEND: begin
        if (xfer_s) begin
          csum_s = csum_add(csum_r, tx_data_r);
          if (byte_cnt_r == LAST_BYTE) begin
            if (rd_addr_r == LAST_BIN) begin
              state_s   = ST_CSUM;
              tx_data_s = csum_add(csum_r, tx_data_r);
            end else begin
              state_s    = ST_FETCH;
              rd_addr_s  = rd_addr_r + 1'b1;
              tx_valid_s = 1'b0;
              rd_en_s    = 1'b1;
            end
          end else begin
            state_s    = ST_SEND;
            tx_data_s  = top_byte(shift_r);
            shift_s    = shift_r << 4'd8;
            byte_cnt_s = byte_cnt_r + 1'b1;
          end
        end else begin
          state_s = ST_SEND;
        end
      end

      ST_CSUM: begin
        if (xfer_s) begin
          state_s    = ST_DONE;
          tx_valid_s = 1'b0;
          busy_s     = 1'b0;
          done_s     = 1'b1;
        end else begin
          state_s    = ST_CSUM;
        end
      end

      ST_DONE: begin
        // start is deliberately not looked at here.
        state_s = ST_IDLE;
        done_s  = 1'b0;
      end

      default: begin
        state_s    = ST_IDLE;
        tx_valid_s = 1'b0;
        rd_en_s    = 1'b0;
        busy_s     = 1'b0;
        done_s     = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      tx_data_r  <= 8'h00;
      tx_valid_r <= 1'b0;
      rd_en_r    <= 1'b0;
      rd_addr_r  <= {BIN_W{1'b0}};
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      shift_r    <= {COUNT_W{1'b0}};
      csum_r     <= 8'h00;
      byte_cnt_r <= {CNT_W{1'b0}};
      fid_r      <= 8'h00;
    end else begin
      state_r    <= state_s;
      tx_data_r  <= tx_data_s;
      tx_valid_r <= tx_valid_s;
      rd_en_r    <= rd_en_s;
      rd_addr_r  <= rd_addr_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
      shift_r    <= shift_s;
      csum_r     <= csum_s;
      byte_cnt_r <= byte_cnt_s;
      fid_r      <= fid_s;
    end
  end

  assign tx_data  = tx_data_r;
  assign tx_valid = tx_valid_r;
  assign rd_en    = rd_en_r;
  assign rd_addr  = rd_addr_r;
  assign busy     = busy_r;
  assign done     = done_r;

endmodule

// File: tb/tb_histo_packetizer.sv
// Testbench for histo_packetizer: randomized tx_ready and histogram contents,
// checked byte-for-byte against a packet built from the framing rules.
module tb_histo_packetizer;

  localparam int BINS    = 1024;
  localparam int BIN_W   = 10;
  localparam int COUNT_W = 24;
  localparam int NB      = COUNT_W / 8;
  localparam int TOTAL   = 3 + BINS * NB + 1;
  localparam int MIN_CYC = 3 + BINS * (2 + NB) + 1 + 1;
  localparam int LIMIT   = 20000;

  logic               clk;
  logic               reset;
  logic               start;
  logic [7:0]         frame_id;
  logic               rd_en;
  logic [BIN_W-1:0]   rd_addr;
  logic [COUNT_W-1:0] rd_data;
  logic [7:0]         tx_data;
  logic               tx_valid;
  logic               tx_ready;
  logic               busy;
  logic               done;

  histo_packetizer #(
    .BINS(BINS), .BIN_W(BIN_W), .COUNT_W(COUNT_W), .SYNC0(8'hAA), .SYNC1(8'h55)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .frame_id(frame_id),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Histogram memory model: data one cycle after rd_en, garbage otherwise.
  logic [COUNT_W-1:0] mem [BINS];
  always @(posedge clk) rd_data <= rd_en ? mem[rd_addr] : COUNT_W'($urandom);

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  logic [7:0] exp_q[$];
  bit   mon_en = 1'b0;
  int   bytes_seen = 0, rd_cnt = 0, done_cnt = 0, cyc = 0;
  int   byte_base = 0, rd_base = 0, done_base = 0, cyc_base = 0;
  bit   prev_stall = 1'b0;
  bit   prev_busy  = 1'b0;
  logic [7:0] prev_data = 8'h00;

  // Protocol monitor: byte stream, stall stability, read order, done/busy.
  always @(negedge clk) begin
    prev_stall <= tx_valid && !tx_ready;
    prev_data  <= tx_data;
    prev_busy  <= busy;
    if (mon_en) begin
      if (prev_stall) begin
        check_eq("hold_valid", 32'(tx_valid), 32'd1);
        check_eq("hold_data", 32'(tx_data), 32'(prev_data));
      end
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) check_eq("extra_byte", 32'(exp_q.size()), 32'd1);
        else check_eq("byte", 32'(tx_data), 32'(exp_q.pop_front()));
        bytes_seen <= bytes_seen + 1;
      end
      if (rd_en) begin
        check_eq("rd_addr", 32'(rd_addr), 32'(rd_cnt - rd_base));
        check_eq("rd_gap", 32'(bytes_seen - byte_base), 32'(3 + (rd_cnt - rd_base) * NB));
        rd_cnt <= rd_cnt + 1;
      end
      if (done) begin
        check_eq("busy_at_done", 32'(busy), 32'd0);
        check_eq("busy_before_done", 32'(prev_busy), 32'd1);
        done_cnt <= done_cnt + 1;
      end
      if (busy || done) cyc <= cyc + 1;
    end
  end

  // Reference packet: sync, frame id, counts MSB first, mod-256 checksum.
  task automatic build_exp(input logic [7:0] fid);
    logic [7:0] sum;
    logic [7:0] b;
    exp_q.delete();
    exp_q.push_back(8'hAA);
    exp_q.push_back(8'h55);
    exp_q.push_back(fid);
    sum = fid;
    for (int i = 0; i < BINS; i++) begin
      for (int k = NB - 1; k >= 0; k--) begin
        b = 8'((mem[i] >> (8 * k)) & 24'hFF);
        exp_q.push_back(b);
        sum = sum + b;
      end
    end
    exp_q.push_back(sum);
  endtask

  task automatic fill(input int mode);
    for (int i = 0; i < BINS; i++) begin
      case (mode)
        0:       mem[i] = 24'h000000;
        1:       mem[i] = 24'(i);
        2:       mem[i] = 24'hFFFFFF;
        default: mem[i] = 24'($urandom);
      endcase
    end
  endtask

  // One packet; optional random tx_ready, ignored-start pokes, or abort by reset.
  task automatic run_packet(input logic [7:0] fid, input bit rnd, input bit poke, input int abort_bin);
    bit fin = 1'b0;
    bit poked = 1'b0;
    bit done_next = 1'b0;
    int t = 0;
    build_exp(fid);
    byte_base = bytes_seen; rd_base = rd_cnt; done_base = done_cnt; cyc_base = cyc;
    mon_en   = 1'b1;
    start    = 1'b1;
    frame_id = fid;
    tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    while (!fin && t < LIMIT) begin
      @(posedge clk); #1;
      t++;
      frame_id  = ~fid;
      start     = done_next;
      done_next = 1'b0;
      if (poke && !poked && (bytes_seen - byte_base) == 10) begin
        start = 1'b1;
        poked = 1'b1;
      end
      tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (poke && tx_valid && tx_ready && (bytes_seen - byte_base) == TOTAL - 1) done_next = 1'b1;
      if (abort_bin >= 0 && tx_valid && rd_addr == BIN_W'(abort_bin)) begin
        reset = 1'b1;
        @(posedge clk); #1;
        reset  = 1'b0;
        mon_en = 1'b0;
        check_eq("abort_valid", 32'(tx_valid), 32'd0);
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_addr", 32'(rd_addr), 32'd0);
        check_eq("abort_rd_en", 32'(rd_en), 32'd0);
        check_eq("abort_data", 32'(tx_data), 32'd0);
        check_eq("abort_done", 32'(done), 32'd0);
        for (int j = 0; j < 10; j++) begin
          @(posedge clk); #1;
          check_eq("abort_no_done", 32'(done), 32'd0);
          check_eq("abort_idle", 32'(busy), 32'd0);
        end
        return;
      end
      if (done_cnt != done_base) fin = 1'b1;
    end
    start = 1'b0;
    for (int j = 0; j < 20; j++) begin
      @(posedge clk); #1;
    end
    check_eq("finished", 32'(fin), 32'd1);
    check_eq("byte_count", 32'(bytes_seen - byte_base), 32'(TOTAL));
    check_eq("exp_left", 32'(exp_q.size()), 32'd0);
    check_eq("rd_count", 32'(rd_cnt - rd_base), 32'(BINS));
    check_eq("done_count", 32'(done_cnt - done_base), 32'd1);
    check_eq("busy_idle", 32'(busy), 32'd0);
    check_eq("valid_idle", 32'(tx_valid), 32'd0);
    if (!rnd) check_eq("cycles", 32'(cyc - cyc_base), 32'(MIN_CYC));
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    frame_id = 8'h00;
    tx_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    start    = 1'b1;
    frame_id = 8'h99;
    @(posedge clk); #1;
    check_eq("rst_valid", 32'(tx_valid), 32'd0);
    check_eq("rst_data", 32'(tx_data), 32'd0);
    check_eq("rst_rd_en", 32'(rd_en), 32'd0);
    check_eq("rst_addr", 32'(rd_addr), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    start = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
    check_eq("start_under_reset", 32'(busy), 32'd0);

    fill(0); run_packet(8'h07, 1'b0, 1'b0, -1);
    fill(1); run_packet(8'h07, 1'b0, 1'b0, -1);
    run_packet(8'h07, 1'b1, 1'b0, -1);
    fill(2); run_packet(8'h00, 1'b0, 1'b0, -1);
    fill(3); run_packet(8'($urandom), 1'b1, 1'b0, -1);
    fill(1); run_packet(8'h3C, 1'b0, 1'b1, -1);
    fill(3); run_packet(8'h5A, 1'b0, 1'b0, 300);
    run_packet(8'hC3, 1'b0, 1'b0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/histo_packetizer.md
Name: histo_packetizer

Overview:
Downstream stage of the histogram generator. On a start pulse after histogram completion, it reads every bin from the histogram read port in order. It frames the counts into a byte packet (sync word, frame ID, counts MSB-first, checksum) and streams the bytes over a valid/ready interface to the UART transmitter. This replaces per-bin serializer control with a single self-contained framed transfer per frame.

Parameters:
BINS, 1024, number of histogram bins read per packet
BIN_W, 10, bin address width (clog2 of BINS)
COUNT_W, 24, bin count width; must be a multiple of 8
SYNC0, 8'hAA, first sync byte
SYNC1, 8'h55, second sync byte

Ports:
clk  in  1  single clock for all logic
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse: histogram complete, begin packet
frame_id  in  8  frame number, sampled on accepted start
rd_en  out  1  histogram read strobe
rd_addr  out  BIN_W  histogram bin address
rd_data  in  COUNT_W  bin count, valid exactly 1 cycle after rd_en
tx_data  out  8  byte to UART transmitter
tx_valid  out  1  tx_data valid
tx_ready  in  1  transmitter accepts byte when tx_valid && tx_ready
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse after checksum byte accepted

Behaviour:
- Clock and reset: single clock domain. Reset is synchronous and active-high, named clk and reset.
- Reset values: tx_valid=0, tx_data=0, rd_en=0, rd_addr=0, busy=0, done=0. State is IDLE, checksum is 0.
- Byte acceptance: a byte transfers on any cycle with tx_valid && tx_ready.
  - While tx_valid=1 and tx_ready=0, tx_data is held stable.
  - tx_valid never drops without a transfer, except on reset.
- Packet format, 3 + BINS*COUNT_W/8 + 1 bytes (3076 at defaults):
  - SYNC0, SYNC1, frame_id
  - For bin 0..BINS-1: count bytes MSB first
  - Checksum byte
- Checksum: 8-bit sum mod 256 of frame_id and all count bytes. Sync bytes and the checksum byte itself are excluded.
- States:
  - IDLE: start=1 latches frame_id, sets busy=1, clears checksum, goes to SYNC0. start is ignored in every other state.
  - SYNC0, SYNC1, FID: present the byte with tx_valid=1; advance on transfer. On the FID transfer, rd_addr=0 and go to FETCH.
  - FETCH: rd_en=1 for exactly one cycle at rd_addr, then go to LATCH.
  - LATCH: capture rd_data into a COUNT_W shift register, then go to SEND.
  - SEND: present the shift register's top byte. On each transfer, add the byte to the checksum and shift left 8.
    - After COUNT_W/8 bytes: if rd_addr==BINS-1 go to CSUM; else increment rd_addr and go to FETCH.
  - CSUM: present the checksum byte. On transfer, go to DONE.
  - DONE: busy=0 and done=1 for one cycle, then go to IDLE. A start in this cycle is ignored.
- Bin read rules:
  - No read is issued while bytes of the previous bin are pending; the histogram RAM is read strictly once per bin.
  - rd_addr is stable from FETCH through the last SEND of that bin.
  - rd_addr wraps to 0 only via reset or a new packet, never by overflow.
- Per-bin overhead: 2 idle cycles (FETCH, LATCH) with tx_valid=0.
- Minimum packet time with tx_ready held at 1: 3 + BINS*(2 + COUNT_W/8) + 1 + 1 cycles.
- start and reset in the same cycle: reset wins.
- Reset mid-packet: next cycle all outputs are at their reset values. The partial packet is abandoned, and no done is produced.
- rd_data is ignored outside the LATCH cycle.

Test Plan:
- All-zero histogram, frame_id=8'h07, tx_ready=1 → 3076 bytes: AA 55 07, 3072×00, checksum 07. done pulses once and busy falls with it. Total cycles = 5125.
- Bin i holds count i → bin 1 bytes are 00 00 01, bin 1023 bytes are 00 03 FF. Checksum = (0x07 + Σ bytes) mod 256. The bench model compares byte-for-byte; exactly 1024 rd_en pulses are seen, with addresses 0..1023 in order.
- All bins FFFFFF, frame_id=00 → every count byte is FF. Checksum = (3072×255) mod 256 = 00.
- Random tx_ready (50%) → the packet is identical to the tx_ready=1 run, and tx_data never changes while tx_valid=1 and tx_ready=0.
- start pulsed at byte 10 and again in the DONE cycle → both ignored, and frame_id is unchanged in the output. Exactly one packet is produced.
- reset asserted while sending bin 300 → next cycle tx_valid=0, busy=0, rd_addr=0, and no done. A new start then yields a complete correct packet.
